// File: rtl/reg_wb_arb.sv
// Write-back arbiter for the shared register-file write port (ALU, RAM load, I/O),
// round-robin shared, with an 8-entry busy scoreboard fed by the issue stage.
module reg_wb_arb (
   input  logic        CLK_WB,
   input  logic        RESET_N,
   input  logic [2:0]  REQ,
   input  logic [2:0]  N_REG_0,
   input  logic [2:0]  N_REG_1,
   input  logic [2:0]  N_REG_2,
   input  logic [15:0] DATA_0,
   input  logic [15:0] DATA_1,
   input  logic [15:0] DATA_2,
   output logic [2:0]  GNT,
   input  logic        RSV_EN,
   input  logic [2:0]  RSV_REG,
   output logic        RSV_CONFLICT,
   output logic [2:0]  N_REG,
   output logic [15:0] REG_IN,
   output logic        REG_WEN,
   output logic [7:0]  BUSY
);

   logic [1:0]  last_r;
   logic [2:0]  pick_s;
   logic [1:0]  sel_s;
   logic [2:0]  gnt_s;
   logic [2:0]  n_reg_sel_s;
   logic [15:0] data_sel_s;
   logic [7:0]  clr_mask_s;
   logic [7:0]  set_mask_s;
   logic [7:0]  busy_nxt_s;

   // Returns {found, index} of the first requester after last, wrapping mod 3.
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] first;
      logic [1:0] second;
      logic [1:0] third;
      case (last)
         2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
         2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
         default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
      endcase
      if (req[first]) begin
         rr_pick = {1'b1, first};
      end else if (req[second]) begin
         rr_pick = {1'b1, second};
      end else if (req[third]) begin
         rr_pick = {1'b1, third};
      end else begin
         rr_pick = 3'b000;
      end
   endfunction

   // Grant selection and write-data mux of the winning requester.
   always_comb begin
      pick_s = rr_pick(REQ, last_r);
      sel_s  = pick_s[1:0];
      if (RESET_N && pick_s[2]) begin
         gnt_s = 3'b001 << sel_s;
      end else begin
         gnt_s = 3'b000;
      end
      case (sel_s)
         2'd0:    begin n_reg_sel_s = N_REG_0; data_sel_s = DATA_0; end
         2'd1:    begin n_reg_sel_s = N_REG_1; data_sel_s = DATA_1; end
         default: begin n_reg_sel_s = N_REG_2; data_sel_s = DATA_2; end
      endcase
   end

   assign GNT          = gnt_s;
   assign RSV_CONFLICT = RESET_N & RSV_EN & BUSY[RSV_REG];

   // Set is OR-ed in after the clear so a same-edge reserve of the written register wins.
   always_comb begin
      clr_mask_s = REG_WEN ? (8'h01 << N_REG) : 8'h00;
      set_mask_s = (RSV_EN && !RSV_CONFLICT) ? (8'h01 << RSV_REG) : 8'h00;
      busy_nxt_s = (BUSY & ~clr_mask_s) | set_mask_s;
   end

   // Registered write port toward reg_wb, pointer update and scoreboard state.
   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         last_r  <= 2'd2;
         N_REG   <= 3'd0;
         REG_IN  <= 16'h0000;
         REG_WEN <= 1'b0;
         BUSY    <= 8'h00;
      end else begin
         if (gnt_s != 3'b000) begin
            last_r  <= sel_s;
            N_REG   <= n_reg_sel_s;
            REG_IN  <= data_sel_s;
            REG_WEN <= 1'b1;
         end else begin
            REG_WEN <= 1'b0;
         end
         BUSY <= busy_nxt_s;
      end
   end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Scoreboard bench for reg_wb_arb: stimulus computes expected writes from a
// round-robin/scoreboard reference model; a monitor compares what reaches reg_wb.
module tb_reg_wb_arb;

   logic        CLK_WB = 1'b0;
   logic        RESET_N = 1'b0;
   logic [2:0]  REQ = 3'b000;
   logic [2:0]  N_REG_0 = 3'd0, N_REG_1 = 3'd0, N_REG_2 = 3'd0;
   logic [15:0] DATA_0 = 16'h0, DATA_1 = 16'h0, DATA_2 = 16'h0;
   logic [2:0]  GNT;
   logic        RSV_EN = 1'b0;
   logic [2:0]  RSV_REG = 3'd0;
   logic        RSV_CONFLICT;
   logic [2:0]  N_REG;
   logic [15:0] REG_IN;
   logic        REG_WEN;
   logic [7:0]  BUSY;

   reg_wb_arb dut (
      .CLK_WB(CLK_WB), .RESET_N(RESET_N), .REQ(REQ),
      .N_REG_0(N_REG_0), .N_REG_1(N_REG_1), .N_REG_2(N_REG_2),
      .DATA_0(DATA_0), .DATA_1(DATA_1), .DATA_2(DATA_2),
      .GNT(GNT), .RSV_EN(RSV_EN), .RSV_REG(RSV_REG), .RSV_CONFLICT(RSV_CONFLICT),
      .N_REG(N_REG), .REG_IN(REG_IN), .REG_WEN(REG_WEN), .BUSY(BUSY)
   );

   always #5 CLK_WB = ~CLK_WB;

   typedef struct {
      int          due;
      logic [2:0]  r;
      logic [15:0] d;
   } wr_t;

   wr_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         m_last = 2;
   logic [7:0] m_busy = 8'h00;
   bit         m_pend = 1'b0;
   logic [2:0] m_pend_reg = 3'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expected write whenever reg_wb is written, checks BUSY each edge.
   always @(posedge CLK_WB) begin
      wr_t e;
      cyc++;
      #1;
      if (RESET_N) begin
         if (REG_WEN === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_write", {31'd0, REG_WEN}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wb_due", cyc, e.due);
               chk("wb_reg", {29'd0, N_REG}, {29'd0, e.r});
               chk("wb_data", {16'd0, REG_IN}, {16'd0, e.d});
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_write", {31'd0, REG_WEN}, 32'd1);
         end
         chk("busy", {24'd0, BUSY}, {24'd0, m_busy});
      end
   end

   task automatic model_reset();
      m_last = 2;
      m_busy = 8'h00;
      m_pend = 1'b0;
      exp_q.delete();
   endtask

   // One cycle of stimulus; the model predicts GNT/RSV_CONFLICT now and the post-edge state.
   task automatic drive(input logic [2:0] req, input logic [2:0] r0, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic rsv_en, input logic [2:0] rsv_reg);
      logic [2:0]  rr[3];
      logic [15:0] dd[3];
      logic [2:0]  eg;
      logic        ecf;
      int          w;
      wr_t         e;
      @(negedge CLK_WB);
      REQ = req; N_REG_0 = r0; N_REG_1 = r1; N_REG_2 = r2;
      DATA_0 = d0; DATA_1 = d1; DATA_2 = d2; RSV_EN = rsv_en; RSV_REG = rsv_reg;
      rr[0] = r0; rr[1] = r1; rr[2] = r2;
      dd[0] = d0; dd[1] = d1; dd[2] = d2;
      #1;
      w = -1;
      for (int k = 1; k <= 3; k++) begin
         if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
      end
      eg = (w >= 0) ? 3'(1 << w) : 3'b000;
      chk("gnt", {29'd0, GNT}, {29'd0, eg});
      ecf = rsv_en && m_busy[rsv_reg];
      chk("rsv_conflict", {31'd0, RSV_CONFLICT}, {31'd0, ecf});
      if (m_pend) m_busy[m_pend_reg] = 1'b0;
      if (rsv_en && !ecf) m_busy[rsv_reg] = 1'b1;
      if (w >= 0) begin
         e.due = cyc + 1; e.r = rr[w]; e.d = dd[w];
         exp_q.push_back(e);
         m_last = w;
         m_pend = 1'b1;
         m_pend_reg = rr[w];
      end else begin
         m_pend = 1'b0;
      end
   endtask

   task automatic idle();
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK_WB);
      RESET_N = 1'b0;
      REQ = 3'b000; RSV_EN = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK_WB);
      RESET_N = 1'b1;
   endtask

   task automatic rand_cycle();
      drive(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom));
   endtask

   initial begin
      REQ = 3'b111; RSV_EN = 1'b1; RSV_REG = 3'd4;
      #1;
      chk("rst_wen", {31'd0, REG_WEN}, 32'd0);
      chk("rst_nreg", {29'd0, N_REG}, 32'd0);
      chk("rst_regin", {16'd0, REG_IN}, 32'd0);
      chk("rst_busy", {24'd0, BUSY}, 32'd0);
      chk("rst_gnt", {29'd0, GNT}, 32'd0);
      chk("rst_conflict", {31'd0, RSV_CONFLICT}, 32'd0);
      REQ = 3'b000; RSV_EN = 1'b0;
      @(negedge CLK_WB);
      RESET_N = 1'b1;

      // single write from requester 0
      drive(3'b001, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h0, 16'h0, 1'b0, 3'd0);
      idle(); idle();

      // round-robin with all requesters from a fresh pointer
      do_reset();
      for (int i = 0; i < 6; i++)
         drive(3'b111, 3'(i), 3'(i + 1), 3'(i + 2), 16'(16'h1000 + i), 16'(16'h2000 + i),
               16'(16'h3000 + i), 1'b0, 3'd0);
      idle();

      // reserve r5, conflicting re-reserve, requester 1 writes r5
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd5);
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd5);
      drive(3'b010, 3'd0, 3'd5, 3'd0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 3'd0);
      idle(); idle();

      // same-edge clear of r2 against a reservation of r2, then retry
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2);
      drive(3'b001, 3'd2, 3'd0, 3'd0, 16'hA5A5, 16'h0, 16'h0, 1'b0, 3'd0);
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2);
      drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2);
      idle();

      // partial contention after requester 1 wins
      drive(3'b010, 3'd1, 3'd6, 3'd1, 16'h1, 16'h6666, 16'h1, 1'b0, 3'd0);
      drive(3'b110, 3'd1, 3'd6, 3'd7, 16'h1, 16'h6161, 16'h7777, 1'b0, 3'd0);
      drive(3'b110, 3'd1, 3'd6, 3'd7, 16'h1, 16'h6262, 16'h7878, 1'b0, 3'd0);
      idle();

      for (int i = 0; i < 400; i++) rand_cycle();
      idle(); idle();

      // async reset with a write on the port and every register busy
      do_reset();
      for (int i = 0; i < 8; i++)
         drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'(i));
      drive(3'b001, 3'd3, 3'd0, 3'd0, 16'hCAFE, 16'h0, 16'h0, 1'b0, 3'd0);
      @(posedge CLK_WB);
      #3;
      chk("pre_rst_wen", {31'd0, REG_WEN}, 32'd1);
      chk("pre_rst_busy", {24'd0, BUSY}, 32'hFF);
      REQ = 3'b111; RSV_EN = 1'b1; RSV_REG = 3'd1;
      RESET_N = 1'b0;
      #1;
      chk("arst_wen", {31'd0, REG_WEN}, 32'd0);
      chk("arst_nreg", {29'd0, N_REG}, 32'd0);
      chk("arst_regin", {16'd0, REG_IN}, 32'd0);
      chk("arst_busy", {24'd0, BUSY}, 32'd0);
      chk("arst_gnt", {29'd0, GNT}, 32'd0);
      chk("arst_conflict", {31'd0, RSV_CONFLICT}, 32'd0);
      model_reset();
      @(negedge CLK_WB);
      REQ = 3'b000; RSV_EN = 1'b0;
      RESET_N = 1'b1;
      drive(3'b111, 3'd4, 3'd5, 3'd6, 16'h0404, 16'h0505, 16'h0606, 1'b0, 3'd0);
      drive(3'b111, 3'd4, 3'd5, 3'd6, 16'h1404, 16'h1505, 16'h1606, 1'b0, 3'd0);
      idle(); idle();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_wb_arb.md
# reg_wb_arb

Write-back arbiter and register scoreboard in front of `reg_wb`. It shares the single register-file write port between three requesters: 0 = ALU, 1 = RAM load, 2 = I/O. Sharing is round-robin, and each granted write is registered one cycle before it drives `reg_wb`. An 8-bit busy scoreboard marks registers reserved by the issue stage and clears each bit when that register's write reaches the file.

## Interface
Parameters:
- none (3 requesters, 8 registers, 16-bit data are fixed)

Ports:
- CLK_WB  in  1  clock; shared with reg_wb
- RESET_N  in  1  reset; asynchronous, active-low
- REQ  in  3  write request per requester; held high until granted
- N_REG_0, N_REG_1, N_REG_2  in  3 each  destination register of requester 0/1/2
- DATA_0, DATA_1, DATA_2  in  16 each  write data of requester 0/1/2
- GNT  out  3  one-hot grant, combinational, same cycle as winning REQ
- RSV_EN  in  1  issue stage reserves a destination register
- RSV_REG  in  3  register to reserve
- RSV_CONFLICT  out  1  combinational, RSV_EN & BUSY[RSV_REG]
- N_REG  out  3  registered write address to reg_wb
- REG_IN  out  16  registered write data to reg_wb
- REG_WEN  out  1  registered write enable to reg_wb
- BUSY  out  8  scoreboard; bit r set = register r has a reserved, unwritten result

## Operation
- Arbitration is combinational over REQ using a 2-bit pointer LAST (values 0..2).
  - Priority order: LAST+1, LAST+2, LAST, each taken mod 3.
  - GNT is one-hot on the first requester asserting REQ in that order, else 0.
  - GNT is forced to 0 while RESET_N=0.
- On each posedge with GNT≠0:
  - LAST <= granted index.
  - N_REG <= N_REG_g, REG_IN <= DATA_g, REG_WEN <= 1.
- On each posedge with GNT=0: REG_WEN <= 0; N_REG and REG_IN hold.
- A requester sees GNT in cycle k and must drop or change REQ/N_REG/DATA for cycle k+1. A still-high REQ in k+1 is a new request.
- Scoreboard, all at posedge:
  - Clear: if REG_WEN=1, BUSY[N_REG] <= 0.
  - Set: if RSV_EN=1 and RSV_CONFLICT=0, BUSY[RSV_REG] <= 1.
  - Set and clear of the same bit at one edge: set wins. This happens only when the reserved register is not busy while an unreserved write to it completes.
  - Reservation with RSV_CONFLICT=1 is ignored, BUSY unchanged. The issue stage stalls and retries.
  - RSV_CONFLICT uses current BUSY with no bypass of a same-cycle clear. A reservation to a register being cleared this edge conflicts and succeeds one cycle later.
  - A write to a non-busy register is legal and leaves BUSY unchanged.
- Destination r=0 is treated like any other register; there is no hardwired zero.

## Timing
- Reset (RESET_N low, asynchronous, any time):
  - REG_WEN=0, N_REG=0, REG_IN=0, BUSY=8'h00, LAST=2, so requester 0 has first priority after reset.
  - GNT=0 and RSV_CONFLICT=0 throughout reset.
  - Reset mid-operation drops any pending registered write; it never reaches reg_wb.
- First posedge after RESET_N rises: normal operation.
- Latency: REQ granted in cycle k → REG_WEN=1 in cycle k+1 → reg_wb captures REG_IN at the posedge ending k+1. The BUSY bit clears at that same edge.
- Throughput: one write per cycle. Back-to-back grants give REG_WEN continuously high.
- Fairness: with all three REQ continuously high, grants rotate 0,1,2,0,... Each requester waits at most 2 cycles.
- Single requester: granted every cycle it requests, regardless of LAST.

## Test plan
- Reset then single write: REQ=3'b001, N_REG_0=3, DATA_0=16'h1234 for one cycle → GNT=001 same cycle; next cycle REG_WEN=1, N_REG=3, REG_IN=16'h1234; following cycle REG_WEN=0.
- Round-robin: REQ=3'b111 held 6 cycles after reset → GNT sequence 001,010,100,001,010,100; REG_WEN high 6 consecutive cycles with matching N_REG/REG_IN.
- Scoreboard: RSV_EN with RSV_REG=5 → BUSY=8'h20. Second RSV_EN with RSV_REG=5 → RSV_CONFLICT=1, BUSY unchanged. Requester 1 writes r5 → BUSY=8'h00 at the edge where REG_WEN=1 is consumed.
- Same-edge clear/reserve: REG_WEN=1, N_REG=2 while RSV_EN with RSV_REG=2 and BUSY[2]=1 → RSV_CONFLICT=1 and BUSY[2]=0 after the edge. Retry next cycle → BUSY[2]=1.
- Partial contention: REQ=3'b110 after requester 1 last granted → GNT=100, then GNT=010.
- Async reset mid-stream: assert RESET_N low between edges while REG_WEN=1 and BUSY=8'hFF → REG_WEN, N_REG, REG_IN and BUSY go to 0 immediately without a clock, GNT=0; after release, requester 0 wins first.
